// File: rtl/innings_score_tracker.sv
// innings_score_tracker: live T20 innings score (runs, wickets, overs, balls, striker) with end-of-innings detection.
// Optional chase target via `define TARGET_CHASE_EN.
module innings_score_tracker #(
   parameter int MAX_OVERS      = 20,
   parameter int MAX_WICKETS    = 10,
   parameter int BALLS_PER_OVER = 6,
   parameter int RUN_W          = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ball_in,
   input  logic [2:0]       runs_in,
   input  logic             wicket_in,
   input  logic             extra_in,
`ifdef TARGET_CHASE_EN
   input  logic [RUN_W-1:0] target,
   output logic             target_reached,
`endif
   output logic [RUN_W-1:0] total_runs,
   output logic [3:0]       wickets,
   output logic [4:0]       overs,
   output logic [2:0]       balls,
   output logic             striker,
   output logic             over_done,
   output logic             innings_over,
   output logic             bad_runs
);
   typedef enum logic [1:0] {READY, IN_PLAY, DONE} state_t;
   state_t state, state_nxt;
   logic start_h, ball_h, start_ev, ball_ev, bad, last, hit, finish;
   logic [2:0] r;
   logic [RUN_W:0] sum;
   logic [RUN_W-1:0] runs_nxt;
   logic [3:0] wk_nxt;
   logic [4:0] ov_nxt;
   always_comb begin
      start_ev = start && !start_h && state == READY;
      ball_ev  = ball_in && !ball_h && state == IN_PLAY;
      bad      = runs_in > 3'd6;
      r        = bad ? 3'd0 : runs_in;
      sum      = {1'b0, total_runs} + (RUN_W+1)'(r) + (RUN_W+1)'(extra_in);
      runs_nxt = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
      last     = !extra_in && balls == 3'(BALLS_PER_OVER - 1);
      wk_nxt   = (wicket_in && wickets < 4'(MAX_WICKETS)) ? wickets + 4'd1 : wickets;
      ov_nxt   = overs + 5'(last);
`ifdef TARGET_CHASE_EN
      hit      = target != '0 && runs_nxt >= target;
`else
      hit      = 1'b0;
`endif
      finish   = hit || wk_nxt == 4'(MAX_WICKETS) || ov_nxt == 5'(MAX_OVERS);
      state_nxt = state;
      if (start_ev) state_nxt = IN_PLAY;
      if (ball_ev && finish) state_nxt = DONE;
   end
   assign innings_over = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= READY;
         start_h    <= 1'b1;
         ball_h     <= 1'b1;
         total_runs <= '0;
         wickets    <= '0;
         overs      <= '0;
         balls      <= '0;
         striker    <= 1'b0;
         over_done  <= 1'b0;
         bad_runs   <= 1'b0;
`ifdef TARGET_CHASE_EN
         target_reached <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         start_h   <= start;
         ball_h    <= ball_in;
         over_done <= ball_ev && last;
         bad_runs  <= ball_ev && bad;
         if (ball_ev) begin
            total_runs <= runs_nxt;
            wickets    <= wk_nxt;
            overs      <= ov_nxt;
            balls      <= last ? 3'd0 : balls + 3'(!extra_in);
            // odd runs swap ends, and so does the change of over
            striker    <= striker ^ r[0] ^ last;
`ifdef TARGET_CHASE_EN
            if (hit) target_reached <= 1'b1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_innings_score_tracker.sv
// tb_innings_score_tracker: randomized scoreboard bench against a cricket-rules reference model.
module tb_innings_score_tracker;
   localparam int RW = 10;
   localparam int MAXR = (1 << RW) - 1;
   logic clk = 0, rst = 1, start = 0, ball_in = 1, wicket_in = 0, extra_in = 0;
   logic [2:0] runs_in = 0;
   logic [RW-1:0] total_runs;
   logic [3:0] wickets;
   logic [4:0] overs;
   logic [2:0] balls;
   logic striker, over_done, innings_over, bad_runs;
`ifdef TARGET_CHASE_EN
   logic [RW-1:0] target = 0;
   logic target_reached;
`endif
   innings_score_tracker #(.MAX_OVERS(20), .MAX_WICKETS(10), .BALLS_PER_OVER(6), .RUN_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .ball_in(ball_in), .runs_in(runs_in),
      .wicket_in(wicket_in), .extra_in(extra_in),
`ifdef TARGET_CHASE_EN
      .target(target), .target_reached(target_reached),
`endif
      .total_runs(total_runs), .wickets(wickets), .overs(overs), .balls(balls),
      .striker(striker), .over_done(over_done), .innings_over(innings_over), .bad_runs(bad_runs));
   always #5 clk = ~clk;

   typedef struct {int total, wk, ov, bl, st, od, io, br, tr;} exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0;
   // reference model: plain cricket arithmetic on integers
   int m_total, m_wk, m_ov, m_bl, m_st, m_od, m_br, m_tr, m_phase, p_start, p_ball;

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("total_runs", int'(total_runs), e.total);
         chk("wickets", int'(wickets), e.wk);
         chk("overs", int'(overs), e.ov);
         chk("balls", int'(balls), e.bl);
         chk("striker", int'(striker), e.st);
         chk("over_done", int'(over_done), e.od);
         chk("innings_over", int'(innings_over), e.io);
         chk("bad_runs", int'(bad_runs), e.br);
`ifdef TARGET_CHASE_EN
         chk("target_reached", int'(target_reached), e.tr);
`endif
      end
   end

   // phase: 0 ready, 1 batting, 2 finished
   task automatic step(input bit rs, input bit s, input bit b, input int rn, input bit w, input bit x);
      int tgt;
      exp_t e;
      @(negedge clk);
      rst = rs; start = s; ball_in = b; runs_in = 3'(rn); wicket_in = w; extra_in = x;
      tgt = 0;
`ifdef TARGET_CHASE_EN
      tgt = int'(target);
`endif
      m_od = 0; m_br = 0;
      if (rs) begin
         m_total = 0; m_wk = 0; m_ov = 0; m_bl = 0; m_st = 0; m_tr = 0; m_phase = 0;
         p_start = 1; p_ball = 1;
      end else begin
         if (m_phase == 0 && s && !p_start) m_phase = 1;
         else if (m_phase == 1 && b && !p_ball) begin
            int runs;
            runs = rn > 6 ? 0 : rn;
            m_br = rn > 6;
            m_total = m_total + runs + x;
            if (m_total > MAXR) m_total = MAXR;
            if (w && m_wk < 10) m_wk++;
            if (!x) begin
               m_bl++;
               if (m_bl == 6) begin m_bl = 0; m_ov++; m_od = 1; end
            end
            if (runs % 2 == 1) m_st = 1 - m_st;
            if (m_od) m_st = 1 - m_st;
            if (tgt != 0 && m_total >= tgt) m_tr = 1;
            if (m_wk == 10 || m_ov == 20 || m_tr) m_phase = 2;
         end
         p_start = s; p_ball = b;
      end
      e = '{m_total, m_wk, m_ov, m_bl, m_st, m_od, int'(m_phase == 2), m_br, m_tr};
      q.push_back(e);
   endtask

   task automatic deliver(input int rn, input bit w, input bit x);
      step(0, 0, 1, rn, w, x);
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic new_innings();
      step(1, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int seq[6] = '{1, 0, 4, 6, 2, 3};
      // reset with ball_in held high: nothing is counted until it falls and rises again
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(0, 0, 1, 5, 0, 0);
      step(0, 1, 1, 5, 0, 0);
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      foreach (seq[i]) deliver(seq[i], 0, 0);
      deliver(4, 0, 1);
      deliver(0, 0, 0);
      deliver(7, 0, 0);
      // ten wickets, then a delivery after the innings is over
      new_innings();
      repeat (10) deliver(1, 1, 0);
      deliver(6, 1, 0);
      step(0, 1, 0, 0, 0, 0);
      // full twenty overs of dot balls
      new_innings();
      repeat (121) deliver(0, 0, 0);
      // run total saturation using extras so overs never advance
      new_innings();
      repeat (150) deliver(6, 0, 1);
      // mid-innings reset with ball_in held high
      new_innings();
      repeat (9) deliver($urandom_range(0, 7), 0, 0);
      step(0, 0, 1, 3, 0, 0);
      step(1, 0, 1, 3, 0, 0);
      step(0, 0, 1, 3, 0, 0);
      step(0, 1, 1, 3, 0, 0);
      deliver(2, 0, 0);
`ifdef TARGET_CHASE_EN
      target = 10;
      new_innings();
      deliver(6, 0, 0);
      deliver(4, 0, 0);
      deliver(1, 0, 0);
      target = 0;
`endif
      for (int n = 0; n < 5; n++) begin
         new_innings();
         for (int k = 0; k < 160; k++) begin
            deliver($urandom_range(0, 7), $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 7) == 0) step(0, $urandom_range(0, 1), 0, 0, 0, 0);
         end
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/innings_score_tracker.md
Name: innings_score_tracker

Overview:
Consumes the registered, synchronised scoring-button levels produced by the input flip-flop stage and keeps the live score for one T20 innings. It tracks total runs, wickets, overs and balls, and the striker end. It detects innings completion and exposes all state as registered outputs for the display/decoder stage downstream.

Parameters:
MAX_OVERS, 20, overs per innings; reaching it ends the innings
MAX_WICKETS, 10, wickets that end the innings
BALLS_PER_OVER, 6, legal deliveries per over
RUN_W, 10, width of run total; saturates at 2^RUN_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  level from flip-flop stage; rising edge starts innings
ball_in  input  1  level from flip-flop stage; rising edge = one delivery event
runs_in  input  3  runs off the delivery, legal values 0..6
wicket_in  input  1  delivery took a wicket
extra_in  input  1  wide/no-ball: +1 penalty run, ball not counted
total_runs  output  RUN_W  innings run total
wickets  output  4  wickets fallen
overs  output  5  completed overs
balls  output  3  legal balls in current over, 0..BALLS_PER_OVER-1
striker  output  1  0 = batter A on strike, 1 = batter B
over_done  output  1  one-cycle pulse on the completing ball of an over
innings_over  output  1  high in DONE state
bad_runs  output  1  one-cycle pulse when runs_in > 6

Behaviour:
- Clock clk; reset rst synchronous, active-high; no asynchronous logic.
- Reset: all counters 0, striker 0, pulses 0, innings_over 0, state READY; edge-detect history registers for start and ball_in reset to 1, so a level held high through reset does not register an event.
- Edge detect: event = input high AND history low, sampled on the same clk edge; history <= input every cycle.
- States: READY -> IN_PLAY on start edge; IN_PLAY -> DONE on end condition; DONE held until rst. start edges outside READY ignored; ball edges outside IN_PLAY ignored.
- Latency: counters update on the clk edge at which the ball edge is detected; outputs valid in the next cycle. At most one delivery processed per cycle.
- Run arithmetic: r = runs_in if <= 6; else r = 0 and bad_runs pulses; other fields of that event are still applied.
- Legal delivery (extra_in=0): total_runs += r; balls += 1. On balls == BALLS_PER_OVER-1: balls <= 0, overs += 1, over_done pulses.
- Extra (extra_in=1): total_runs += 1 + r; balls/overs unchanged; no over_done.
- Saturation: total_runs clamps at 2^RUN_W-1 and never wraps.
- wicket_in: wickets += 1 on legal or extra delivery; no increment past MAX_WICKETS.
- Striker: toggles if r is odd, and toggles again at over completion. An odd run on the last ball gives a net change of none.
- End condition, evaluated on the updated values: wickets == MAX_WICKETS OR overs == MAX_OVERS -> DONE. The final-event counters remain visible; over_done still pulses if that event completed the over.
- DONE: innings_over=1; all inputs ignored; outputs frozen.
- rst mid-innings: every register returns to its reset value on that edge regardless of state.

Optional Feature:
Macro TARGET_CHASE_EN.
- Defined: adds port target input RUN_W and output target_reached (reset 0). In IN_PLAY, if the updated total_runs >= target, go to DONE with target_reached=1 on the same edge. target == 0 never triggers this.
- Not defined: neither port exists; innings ends only on wickets/overs.

Test Plan:
- rst high with ball_in held 1, release rst, pulse start -> all outputs 0, state IN_PLAY, no ball counted until ball_in goes 0 then 1.
- 6 legal balls with runs 1,0,4,6,2,3 -> total_runs=16, overs=1, balls=0, over_done one pulse on 6th ball; striker 1 after ball 1, 1 after ball 6 (odd run plus over-end toggle = no net change).
- Extra with runs_in=4, then legal 0 -> total_runs=5, balls=1; runs_in=7 legal -> bad_runs pulse, runs +0, balls +1.
- 10 deliveries with wicket_in=1 -> innings_over=1 after 10th, wickets=10; 11th ball edge leaves all outputs unchanged.
- 120 legal dot balls -> overs=20, balls=0, innings_over=1; drive RUN_W=4 with 4 sixes -> total_runs saturates at 15.
- TARGET_CHASE_EN, target=10: legal 6 then 4 -> target_reached=1, innings_over=1, total_runs=10; rst mid-over -> everything 0, READY.
